// File: rtl/scan_decoder_if.sv
// Handshake bundle for scan_decoder: control/select in, decoded outputs back.
interface scan_decoder_if #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4
);
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   d;
  logic [NUM_OUT-1:0] q;
  logic [SEL_W-1:0]   idx;
  logic               wrap;
  logic               err;

  modport master (output en, mode, d, input q, idx, wrap, err);
  modport slave  (input en, mode, d, output q, idx, wrap, err);
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot digit decoder with direct-select and prescaled auto-scan modes.
// Optional macro SCAN_DECODER_BLANK_EN inserts one blank cycle on every scan step.
module scan_decoder #(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int PRESCALE   = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic         clk,
  input  logic         rst,
  scan_decoder_if.slave bus
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]    PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0]   IDX_LAST  = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W:0]     NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);
  localparam logic [NUM_OUT-1:0] INACTIVE  = (ACTIVE_LOW != 0) ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};

  typedef enum logic {
    ST_DIRECT,
    ST_SCAN
  } state_t;

  state_t            state;
  logic [PS_W-1:0]   prescale_cnt;
  logic              step;
  logic [SEL_W-1:0]  idx_next;
  logic              in_range;

  // Out-of-range selects naturally decode to all-inactive.
  function automatic logic [NUM_OUT-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [NUM_OUT-1:0] hot;
    hot = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (sel == SEL_W'(k)) hot[k] = 1'b1;
    end
    return hot ^ INACTIVE;
  endfunction

  assign step     = (prescale_cnt == PS_LAST);
  assign idx_next = (bus.idx == IDX_LAST) ? '0 : bus.idx + SEL_W'(1);
  assign in_range = ({1'b0, bus.d} < NUM_OUT_W);

  // Entering scan always restarts at output 0, which also clears any
  // out-of-range index left over from direct mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_DIRECT;
      prescale_cnt <= '0;
      bus.q        <= INACTIVE;
      bus.idx      <= '0;
      bus.wrap     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.wrap <= 1'b0;
      if (bus.en) begin
        if (!bus.mode) begin
          state        <= ST_DIRECT;
          prescale_cnt <= '0;
          bus.idx      <= bus.d;
          bus.q        <= decode(bus.d);
          bus.err      <= !in_range;
        end else if (state != ST_SCAN) begin
          state        <= ST_SCAN;
          prescale_cnt <= '0;
          bus.idx      <= '0;
          bus.q        <= decode('0);
          bus.err      <= 1'b0;
        end else if (step) begin
          prescale_cnt <= '0;
          bus.idx      <= idx_next;
          bus.wrap     <= (idx_next == '0);
          bus.err      <= 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
          bus.q        <= INACTIVE;
`else
          bus.q        <= decode(idx_next);
`endif
        end else begin
          prescale_cnt <= prescale_cnt + PS_W'(1);
          bus.q        <= decode(bus.idx);
          bus.err      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: two parameterisations share one stimulus stream
// and are compared every cycle against a count-based behavioural model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] d   = 2'd0;
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  scan_decoder_if #(.SEL_W(2), .NUM_OUT(4)) bus0 ();
  scan_decoder_if #(.SEL_W(2), .NUM_OUT(3)) bus1 ();

  assign bus0.en = en;
  assign bus0.mode = mode;
  assign bus0.d = d;
  assign bus1.en = en;
  assign bus1.mode = mode;
  assign bus1.d = d;

  scan_decoder #(.SEL_W(2), .NUM_OUT(4), .PRESCALE(4), .ACTIVE_LOW(1)) u0 (
    .clk(clk), .rst(rst), .bus(bus0));
  scan_decoder #(.SEL_W(2), .NUM_OUT(3), .PRESCALE(3), .ACTIVE_LOW(0)) u1 (
    .clk(clk), .rst(rst), .bus(bus1));

  // Model: remembers the phase, the last direct select, and how many enabled
  // scan edges have elapsed since scan entry; outputs derive from that count.
  typedef enum int {PH_RESET, PH_DIRECT, PH_SCAN} phase_t;
  phase_t     m_phase = PH_RESET;
  int         m_n = 0;
  logic [1:0] m_d = 2'd0;
  bit         m_last_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase   <= PH_RESET;
      m_n       <= 0;
      m_last_en <= 1'b0;
    end else begin
      m_last_en <= en;
      if (en) begin
        if (!mode) begin
          m_phase <= PH_DIRECT;
          m_d     <= d;
        end else if (m_phase != PH_SCAN) begin
          m_phase <= PH_SCAN;
          m_n     <= 0;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end
  end

  function automatic void expect_out(input int n_out, input int pre, input bit act_low,
                                     output logic [3:0] e_q, output logic [1:0] e_idx,
                                     output logic e_wrap, output logic e_err);
    logic [3:0] mask;
    logic [3:0] hot;
    int         sel;
    bit         stepped;
    mask   = act_low ? 4'((1 << n_out) - 1) : 4'd0;
    hot    = 4'd0;
    e_idx  = 2'd0;
    e_wrap = 1'b0;
    e_err  = 1'b0;
    case (m_phase)
      PH_DIRECT: begin
        sel   = int'(m_d);
        e_idx = m_d;
        e_err = (sel >= n_out);
        if (sel < n_out) hot = 4'(1 << sel);
      end
      PH_SCAN: begin
        stepped = (m_n > 0) && (m_n % pre == 0);
        sel     = (m_n / pre) % n_out;
        e_idx   = 2'(sel);
        e_wrap  = m_last_en && stepped && (sel == 0);
        hot     = 4'(1 << sel);
`ifdef SCAN_DECODER_BLANK_EN
        if (stepped) hot = 4'd0;
`endif
      end
      default: hot = 4'd0;
    endcase
    e_q = hot ^ mask;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit m, input logic [1:0] dv, input int cycles);
    en   = e;
    mode = m;
    d    = dv;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [3:0] e_q;
    logic [1:0] e_idx;
    logic       e_wrap;
    logic       e_err;
    if (chk_en) begin
      expect_out(4, 4, 1'b1, e_q, e_idx, e_wrap, e_err);
      checkOutput("u0_q",    32'(bus0.q),    32'(e_q));
      checkOutput("u0_idx",  32'(bus0.idx),  32'(e_idx));
      checkOutput("u0_wrap", 32'(bus0.wrap), 32'(e_wrap));
      checkOutput("u0_err",  32'(bus0.err),  32'(e_err));
      expect_out(3, 3, 1'b0, e_q, e_idx, e_wrap, e_err);
      checkOutput("u1_q",    32'(bus1.q),    32'(e_q[2:0]));
      checkOutput("u1_idx",  32'(bus1.idx),  32'(e_idx));
      checkOutput("u1_wrap", 32'(bus1.wrap), 32'(e_wrap));
      checkOutput("u1_err",  32'(bus1.err),  32'(e_err));
    end
  end

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    checkOutput("rst_u0_q",   32'(bus0.q),   32'h0f);
    checkOutput("rst_u0_idx", 32'(bus0.idx), 32'h0);
    checkOutput("rst_u1_q",   32'(bus1.q),   32'h0);
    #2 rst = 1'b0;

    // Direct decode, including the out-of-range select on the 3-output unit.
    applyStimulus(1, 0, 2'd0, 1);
    checkOutput("dir0_u0_q", 32'(bus0.q), 32'b1110);
    checkOutput("dir0_u1_q", 32'(bus1.q), 32'b001);
    applyStimulus(1, 0, 2'd1, 1);
    checkOutput("dir1_u0_q", 32'(bus0.q), 32'b1101);
    checkOutput("dir1_u1_q", 32'(bus1.q), 32'b010);
    applyStimulus(1, 0, 2'd2, 1);
    checkOutput("dir2_u0_q", 32'(bus0.q), 32'b1011);
    checkOutput("dir2_u1_q", 32'(bus1.q), 32'b100);
    applyStimulus(1, 0, 2'd3, 1);
    checkOutput("dir3_u0_q",   32'(bus0.q),   32'b0111);
    checkOutput("dir3_u0_err", 32'(bus0.err), 32'h0);
    checkOutput("oor_u1_q",    32'(bus1.q),   32'b000);
    checkOutput("oor_u1_err",  32'(bus1.err), 32'h1);
    checkOutput("oor_u1_idx",  32'(bus1.idx), 32'h3);
    applyStimulus(1, 0, 2'd1, 1);
    checkOutput("back_u1_q",   32'(bus1.q),   32'b010);
    checkOutput("back_u1_err", 32'(bus1.err), 32'h0);

    // Scan entry and stepping on the 4-output, prescale-4 unit.
    applyStimulus(1, 1, 2'd0, 1);
    checkOutput("entry_u0_idx", 32'(bus0.idx), 32'h0);
    checkOutput("entry_u0_q",   32'(bus0.q),   32'b1110);
    checkOutput("entry_u1_err", 32'(bus1.err), 32'h0);
    applyStimulus(1, 1, 2'd0, 4);
    checkOutput("step1_u0_idx", 32'(bus0.idx), 32'h1);
    checkOutput("step1_u1_idx", 32'(bus1.idx), 32'h1);
    applyStimulus(1, 1, 2'd0, 1);
    checkOutput("step1_u0_q", 32'(bus0.q), 32'b1101);
    applyStimulus(1, 1, 2'd0, 11);
    checkOutput("wrap_u0_idx", 32'(bus0.idx),  32'h0);
    checkOutput("wrap_u0_hi",  32'(bus0.wrap), 32'h1);
    applyStimulus(1, 1, 2'd0, 1);
    checkOutput("wrap_u0_lo", 32'(bus0.wrap), 32'h0);

    // Freeze with the prescaler at 2, then the step lands two edges after release.
    applyStimulus(1, 1, 2'd0, 1);
    applyStimulus(0, 1, 2'd0, 10);
    checkOutput("frz_u0_idx",  32'(bus0.idx),  32'h0);
    checkOutput("frz_u0_q",    32'(bus0.q),    32'b1110);
    checkOutput("frz_u1_wrap", 32'(bus1.wrap), 32'h0);
    applyStimulus(1, 1, 2'd0, 1);
    checkOutput("thaw1_u0_idx", 32'(bus0.idx), 32'h0);
    applyStimulus(1, 1, 2'd0, 1);
    checkOutput("thaw2_u0_idx", 32'(bus0.idx), 32'h1);

    // Asynchronous reset between edges while idx = 2.
    applyStimulus(1, 1, 2'd0, 4);
    checkOutput("pre_rst_u0_idx", 32'(bus0.idx), 32'h2);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_u0_q",    32'(bus0.q),    32'h0f);
    checkOutput("arst_u0_idx",  32'(bus0.idx),  32'h0);
    checkOutput("arst_u0_wrap", 32'(bus0.wrap), 32'h0);
    checkOutput("arst_u1_q",    32'(bus1.q),    32'h0);
    #2 rst = 1'b0;
    applyStimulus(1, 1, 2'd0, 1);
    checkOutput("restart_u0_idx", 32'(bus0.idx), 32'h0);
    applyStimulus(1, 1, 2'd0, 20);

    // Mode changes: scan -> direct, held select under freeze, out-of-range -> scan entry.
    applyStimulus(1, 0, 2'd2, 1);
    checkOutput("s2d_u0_idx", 32'(bus0.idx), 32'h2);
    applyStimulus(0, 1, 2'd3, 3);
    checkOutput("hold_u0_idx", 32'(bus0.idx), 32'h2);
    applyStimulus(1, 0, 2'd3, 1);
    checkOutput("oor2_u1_err", 32'(bus1.err), 32'h1);
    applyStimulus(1, 1, 2'd3, 1);
    checkOutput("reentry_u1_idx", 32'(bus1.idx), 32'h0);
    checkOutput("reentry_u1_err", 32'(bus1.err), 32'h0);

    // Gappy enable pattern during scan.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1, 2'd0, 1);
    end
    applyStimulus(1, 1, 2'd0, 5);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Registered, parametrised N-output one-hot decoder with two modes: direct decode of a binary select, or autonomous scan that steps through outputs at a prescaled rate.
- Drives digit-enable lines of the multiplexed 7-segment display in the digital clock and replaces the fixed combinational 2-to-4 decoder.
- Also reports the current index so the segment data mux stays aligned.

Parameters:
- SEL_W, 2, width of select input and index output.
- NUM_OUT, 4, number of decoded outputs; legal range 2..2**SEL_W.
- PRESCALE, 1000, clk cycles per scan step; legal range is at least 1.
- ACTIVE_LOW, 0, 1 = outputs inverted (active level 0, inactive 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  1 = prescaler and scan advance; 0 = freeze (q, idx held).
- mode  input  1  0 = direct decode of d; 1 = auto-scan.
- d  input  SEL_W  binary select used in direct mode.
- q  output  NUM_OUT  one-hot decoded outputs, registered.
- idx  output  SEL_W  index currently asserted on q, registered.
- wrap  output  1  one-cycle pulse when scan index wraps NUM_OUT-1 -> 0.
- err  output  1  direct mode, d >= NUM_OUT (registered).

Behaviour:
- Reset (async, any time):
  - q = all inactive (0s, or 1s if ACTIVE_LOW).
  - idx = 0, wrap = 0, err = 0, prescaler = 0.
  - First update happens on the first clk edge after rst falls.
- Active level: bit k of q is active iff idx == k and the output is not blanked; all other bits are inactive.
- Direct mode (mode=0):
  - Each clk edge with en=1: idx <= d and q <= decode(d); latency is 1 cycle.
  - If d >= NUM_OUT: q all inactive, idx <= d, err <= 1; otherwise err <= 0.
  - Prescaler is held at 0; wrap = 0.
- Scan mode (mode=1):
  - Prescaler counts 0..PRESCALE-1 while en=1.
  - On the edge where the prescaler equals PRESCALE-1: prescaler <= 0 and idx <= idx+1, or 0 if idx == NUM_OUT-1.
  - On the 0 case, wrap = 1 for exactly that cycle.
  - q tracks idx with no extra latency: q and idx update on the same edge.
  - err = 0.
  - PRESCALE = 1 steps every cycle.
- Mode 0 -> 1 transition: on the first scan-mode edge, idx <= 0, prescaler <= 0, q = decode(0), no wrap pulse. Scan always starts at output 0.
- Mode 1 -> 0 transition: direct decode takes over on the next edge; prescaler cleared.
- en = 0: all registers hold, including the prescaler; wrap forced 0.
- An out-of-range idx (only possible in direct mode) never enters scan mode, because the mode entry resets idx to 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SCAN_DECODER_BLANK_EN.
- Defined:
  - In scan mode, q is forced all-inactive for 1 clk cycle on every index step (the cycle after the step edge); idx already shows the new value.
  - The new output asserts on the following edge.
  - This suppresses ghosting on the display.
  - No effect in direct mode.
- Undefined: no blanking cycle; q changes directly from the old one-hot value to the new one.

Test Plan:
- Reset mid-scan: SEL_W=2, NUM_OUT=4, idx=2, assert rst between edges -> q=0000, idx=0, wrap=0 immediately; after release, scan restarts at idx=0.
- Direct decode: mode=0, en=1, d=0,1,2,3 on successive cycles -> q=0001,0010,0100,1000, each one cycle after d; err=0.
- Out-of-range: NUM_OUT=3, mode=0, d=3 -> next cycle q=000, err=1; then d=1 -> q=010, err=0.
- Scan + wrap: PRESCALE=4, mode=1 -> idx steps 0,1,2,3,0 every 4 cycles; wrap high for exactly 1 cycle at the 3 -> 0 edge; with ACTIVE_LOW=1, q=1110,1101,1011,0111.
- Freeze: PRESCALE=4, en=0 for 10 cycles mid-count at prescaler=2 -> q, idx unchanged; after en=1 the step occurs 2 cycles later.
- Blank feature: SCAN_DECODER_BLANK_EN defined, PRESCALE=3 -> after each step edge q=0000 for 1 cycle, then the new one-hot value; undefined -> no zero cycle.
